scr1_pipe_ialu_muldiv: RTL and testbench



---
 rtl/scr1_pkg.sv | 60 ++++++
 rtl/scr1_ialu_div_step.sv | 21 ++
 rtl/scr1_pipe_ialu_muldiv.sv | 219 +++++++++++++++++++++
 tb/tb_scr1_pipe_ialu_muldiv.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_pkg.sv
// Shared types and command-decode helpers for the SCR1 IALU multiply/divide unit.
package scr1_pkg;

    typedef enum logic [2:0] {
        SCR1_IALU_MD_CMD_MUL    = 3'd0,
        SCR1_IALU_MD_CMD_MULH   = 3'd1,
        SCR1_IALU_MD_CMD_MULHSU = 3'd2,
        SCR1_IALU_MD_CMD_MULHU  = 3'd3,
        SCR1_IALU_MD_CMD_DIV    = 3'd4,
        SCR1_IALU_MD_CMD_DIVU   = 3'd5,
        SCR1_IALU_MD_CMD_REM    = 3'd6,
        SCR1_IALU_MD_CMD_REMU   = 3'd7
    } type_scr1_ialu_md_cmd_e;

    typedef enum logic [2:0] {
        SCR1_IALU_MD_FSM_IDLE = 3'd0,
        SCR1_IALU_MD_FSM_MUL  = 3'd1,
        SCR1_IALU_MD_FSM_DIV  = 3'd2,
        SCR1_IALU_MD_FSM_CORR = 3'd3,
        SCR1_IALU_MD_FSM_DONE = 3'd4
    } type_scr1_ialu_md_fsm_e;

    function automatic logic is_signed_op1(input type_scr1_ialu_md_cmd_e cmd);
        case (cmd)
            SCR1_IALU_MD_CMD_MULH,
            SCR1_IALU_MD_CMD_MULHSU,
            SCR1_IALU_MD_CMD_DIV,
            SCR1_IALU_MD_CMD_REM:    is_signed_op1 = 1'b1;
            default:                 is_signed_op1 = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op2(input type_scr1_ialu_md_cmd_e cmd);
        case (cmd)
            SCR1_IALU_MD_CMD_MULH,
            SCR1_IALU_MD_CMD_DIV,
            SCR1_IALU_MD_CMD_REM:    is_signed_op2 = 1'b1;
            default:                 is_signed_op2 = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_cmd(input type_scr1_ialu_md_cmd_e cmd);
        case (cmd)
            SCR1_IALU_MD_CMD_DIV,
            SCR1_IALU_MD_CMD_DIVU,
            SCR1_IALU_MD_CMD_REM,
            SCR1_IALU_MD_CMD_REMU:   is_div_cmd = 1'b1;
            default:                 is_div_cmd = 1'b0;
        endcase
    endfunction

    function automatic logic is_rem_cmd(input type_scr1_ialu_md_cmd_e cmd);
        case (cmd)
            SCR1_IALU_MD_CMD_REM,
            SCR1_IALU_MD_CMD_REMU:   is_rem_cmd = 1'b1;
            default:                 is_rem_cmd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scr1_ialu_div_step.sv
// One radix-2 restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module scr1_ialu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0]   shifted_s;
    logic [XLEN-1:0] diff_s;

    assign shifted_s = {rem, dvd_bit};
    assign q_bit     = (shifted_s >= {1'b0, divisor});
    // When the subtraction succeeds the difference is below the divisor, so XLEN bits hold it.
    assign diff_s    = shifted_s[XLEN-1:0] - divisor;
    assign rem_next  = q_bit ? diff_s : shifted_s[XLEN-1:0];

endmodule

// File: rtl/scr1_pipe_ialu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit with kill and special-case early completion.
// Optional single-cycle multiplier enabled by SCR1_MULDIV_FAST_MUL_EN.
module scr1_pipe_ialu_muldiv
    import scr1_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int MUL_BITS_PER_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_vd_i,
    input  type_scr1_ialu_md_cmd_e cmd_i,
    input  logic [XLEN-1:0]        op1_i,
    input  logic [XLEN-1:0]        op2_i,
    input  logic                   kill_i,
    output logic                   res_rdy_o,
    output logic [XLEN-1:0]        res_o,
    output logic                   busy_o
);

    localparam int B       = MUL_BITS_PER_CYC;
    localparam int MUL_CYC = XLEN / B;
    localparam int ACC_W   = XLEN + B + 2;
    localparam int CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    type_scr1_ialu_md_fsm_e state_r, state_nxt_s, state_fin_s;
    type_scr1_ialu_md_cmd_e cmd_r, cmd_nxt_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic [XLEN:0]           mcand_r, mcand_nxt_s;
    logic signed [ACC_W-1:0] acc_r, acc_nxt_s;
    logic [XLEN-1:0]         lo_r, lo_nxt_s;
    logic                    sgn2_r, sgn2_nxt_s;
    logic                    neg_q_r, neg_q_nxt_s;
    logic                    neg_rem_r, neg_rem_nxt_s;
    logic                    res_rdy_r;
    logic [XLEN-1:0]         res_r;
    logic                    busy_r;
    logic [XLEN-1:0]         result_s;

    // Command decode on the raw inputs
    logic            sgn1_s, sgn2_in_s, op1_neg_s, op2_neg_s, div_zero_s, div_ovf_s;
    logic [XLEN-1:0] op1_mag_s, op2_mag_s;

    assign sgn1_s     = is_signed_op1(cmd_i);
    assign sgn2_in_s  = is_signed_op2(cmd_i);
    assign op1_neg_s  = sgn1_s & op1_i[XLEN-1];
    assign op2_neg_s  = sgn2_in_s & op2_i[XLEN-1];
    assign op1_mag_s  = op1_neg_s ? (ZERO - op1_i) : op1_i;
    assign op2_mag_s  = op2_neg_s ? (ZERO - op2_i) : op2_i;
    assign div_zero_s = (op2_i == ZERO);
    assign div_ovf_s  = sgn1_s & (op1_i == MIN_NEG) & (op2_i == ALL_ONES);

    // Multiplier step: acc holds the running high part, lo collects product bits from the top.
    // Only the final digit carries the negative weight of a signed multiplier.
    logic                    last_mul_s;
    logic [B:0]              digit_s;
    logic signed [ACC_W-1:0] pp_s, mul_sum_s, mul_acc_nxt_s;
    logic [XLEN-1:0]         mul_lo_nxt_s;

    assign last_mul_s    = (cnt_r == CNT_W'(MUL_CYC - 1));
    assign digit_s       = {last_mul_s & sgn2_r & lo_r[B-1], lo_r[B-1:0]};
    assign pp_s          = $signed({{(ACC_W-XLEN-1){mcand_r[XLEN]}}, mcand_r})
                         * $signed({{(ACC_W-B-1){digit_s[B]}}, digit_s});
    assign mul_sum_s     = acc_r + pp_s;
    assign mul_acc_nxt_s = mul_sum_s >>> B;
    assign mul_lo_nxt_s  = {mul_sum_s[B-1:0], lo_r[XLEN-1:B]};

    // Divider step on magnitudes; lo shifts dividend bits out and quotient bits in
    logic            last_div_s, div_q_bit_s;
    logic [XLEN-1:0] div_rem_nxt_s, q_corr_s, r_corr_s;

    assign last_div_s = (cnt_r == CNT_W'(XLEN - 1));

    scr1_ialu_div_step #(
        .XLEN (XLEN)
    ) i_div_step (
        .rem      (acc_r[XLEN-1:0]),
        .dvd_bit  (lo_r[XLEN-1]),
        .divisor  (mcand_r[XLEN-1:0]),
        .rem_next (div_rem_nxt_s),
        .q_bit    (div_q_bit_s)
    );

    assign q_corr_s = neg_q_r ? (ZERO - lo_r) : lo_r;
    assign r_corr_s = neg_rem_r ? (ZERO - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];

`ifdef SCR1_MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a_s, fast_b_s, fast_p_s;

    assign fast_a_s = $signed({{XLEN{op1_neg_s}}, op1_i});
    assign fast_b_s = $signed({{XLEN{op2_neg_s}}, op2_i});
    assign fast_p_s = fast_a_s * fast_b_s;
`endif

    // Next-state and datapath selection
    always_comb begin
        state_nxt_s   = state_r;
        cmd_nxt_s     = cmd_r;
        cnt_nxt_s     = cnt_r;
        mcand_nxt_s   = mcand_r;
        acc_nxt_s     = acc_r;
        lo_nxt_s      = lo_r;
        sgn2_nxt_s    = sgn2_r;
        neg_q_nxt_s   = neg_q_r;
        neg_rem_nxt_s = neg_rem_r;
        result_s      = ZERO;
        case (state_r)
            SCR1_IALU_MD_FSM_IDLE: begin
                if (cmd_vd_i) begin
                    cmd_nxt_s     = cmd_i;
                    cnt_nxt_s     = {CNT_W{1'b0}};
                    acc_nxt_s     = {ACC_W{1'b0}};
                    sgn2_nxt_s    = sgn2_in_s;
                    neg_q_nxt_s   = op1_neg_s ^ op2_neg_s;
                    neg_rem_nxt_s = op1_neg_s;
                    if (is_div_cmd(cmd_i)) begin
                        mcand_nxt_s = {1'b0, op2_mag_s};
                        lo_nxt_s    = op1_mag_s;
                        if (div_zero_s) begin
                            state_nxt_s = SCR1_IALU_MD_FSM_DONE;
                            result_s    = is_rem_cmd(cmd_i) ? op1_i : ALL_ONES;
                        end else if (div_ovf_s) begin
                            state_nxt_s = SCR1_IALU_MD_FSM_DONE;
                            result_s    = is_rem_cmd(cmd_i) ? ZERO : op1_i;
                        end else begin
                            state_nxt_s = SCR1_IALU_MD_FSM_DIV;
                        end
                    end else begin
                        mcand_nxt_s = {op1_neg_s, op1_i};
                        lo_nxt_s    = op2_i;
`ifdef SCR1_MULDIV_FAST_MUL_EN
                        state_nxt_s = SCR1_IALU_MD_FSM_DONE;
                        result_s    = (cmd_i == SCR1_IALU_MD_CMD_MUL) ? fast_p_s[XLEN-1:0]
                                                                      : fast_p_s[2*XLEN-1:XLEN];
`else
                        state_nxt_s = SCR1_IALU_MD_FSM_MUL;
`endif
                    end
                end else begin
                    state_nxt_s = SCR1_IALU_MD_FSM_IDLE;
                end
            end
            SCR1_IALU_MD_FSM_MUL: begin
                acc_nxt_s = mul_acc_nxt_s;
                lo_nxt_s  = mul_lo_nxt_s;
                cnt_nxt_s = cnt_r + CNT_W'(1);
                if (last_mul_s) begin
                    state_nxt_s = SCR1_IALU_MD_FSM_DONE;
                    result_s    = (cmd_r == SCR1_IALU_MD_CMD_MUL) ? mul_lo_nxt_s
                                                                  : mul_acc_nxt_s[XLEN-1:0];
                end else begin
                    state_nxt_s = SCR1_IALU_MD_FSM_MUL;
                end
            end
            SCR1_IALU_MD_FSM_DIV: begin
                acc_nxt_s = {{(ACC_W-XLEN){1'b0}}, div_rem_nxt_s};
                lo_nxt_s  = {lo_r[XLEN-2:0], div_q_bit_s};
                cnt_nxt_s = cnt_r + CNT_W'(1);
                if (last_div_s) begin
                    state_nxt_s = SCR1_IALU_MD_FSM_CORR;
                end else begin
                    state_nxt_s = SCR1_IALU_MD_FSM_DIV;
                end
            end
            SCR1_IALU_MD_FSM_CORR: begin
                state_nxt_s = SCR1_IALU_MD_FSM_DONE;
                result_s    = is_rem_cmd(cmd_r) ? r_corr_s : q_corr_s;
            end
            SCR1_IALU_MD_FSM_DONE: begin
                state_nxt_s = SCR1_IALU_MD_FSM_IDLE;
            end
            default: begin
                state_nxt_s = SCR1_IALU_MD_FSM_IDLE;
            end
        endcase
    end

    // A kill overrides every transition, including acceptance in IDLE
    assign state_fin_s = kill_i ? SCR1_IALU_MD_FSM_IDLE : state_nxt_s;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= SCR1_IALU_MD_FSM_IDLE;
            cmd_r     <= SCR1_IALU_MD_CMD_MUL;
            cnt_r     <= {CNT_W{1'b0}};
            mcand_r   <= {(XLEN+1){1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            lo_r      <= ZERO;
            sgn2_r    <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            res_rdy_r <= 1'b0;
            res_r     <= ZERO;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_fin_s;
            cmd_r     <= cmd_nxt_s;
            cnt_r     <= cnt_nxt_s;
            mcand_r   <= mcand_nxt_s;
            acc_r     <= acc_nxt_s;
            lo_r      <= lo_nxt_s;
            sgn2_r    <= sgn2_nxt_s;
            neg_q_r   <= neg_q_nxt_s;
            neg_rem_r <= neg_rem_nxt_s;
            res_rdy_r <= (state_fin_s == SCR1_IALU_MD_FSM_DONE);
            res_r     <= (state_fin_s == SCR1_IALU_MD_FSM_DONE) ? result_s : ZERO;
            busy_r    <= (state_fin_s != SCR1_IALU_MD_FSM_IDLE);
        end
    end

    assign res_rdy_o = res_rdy_r;
    assign res_o     = res_r;
    assign busy_o    = busy_r;

endmodule

// File: tb/tb_scr1_pipe_ialu_muldiv.sv
// Self-checking bench: directed vector table, kill/reset sequences and randomized ops vs a behavioural model.
module tb_scr1_pipe_ialu_muldiv;
    import scr1_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, kill;
    type_scr1_ialu_md_cmd_e cmd;
    logic [31:0] op1, op2, res_a, res_b;
    logic vd_a, vd_b, rdy_a, rdy_b, busy_a, busy_b;
    logic [63:0] op1_w, op2_w, res_w;
    logic vd_w, rdy_w, busy_w;

    int total = 0;
    int passed = 0;

    scr1_pipe_ialu_muldiv #(.XLEN(32), .MUL_BITS_PER_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_vd_i(vd_a), .cmd_i(cmd), .op1_i(op1), .op2_i(op2),
        .kill_i(kill), .res_rdy_o(rdy_a), .res_o(res_a), .busy_o(busy_a));

    scr1_pipe_ialu_muldiv #(.XLEN(32), .MUL_BITS_PER_CYC(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_vd_i(vd_b), .cmd_i(cmd), .op1_i(op1), .op2_i(op2),
        .kill_i(kill), .res_rdy_o(rdy_b), .res_o(res_b), .busy_o(busy_b));

    scr1_pipe_ialu_muldiv #(.XLEN(64), .MUL_BITS_PER_CYC(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .cmd_vd_i(vd_w), .cmd_i(cmd), .op1_i(op1_w), .op2_i(op2_w),
        .kill_i(kill), .res_rdy_o(rdy_w), .res_o(res_w), .busy_o(busy_w));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Behavioural reference: plain wide signed arithmetic on the RISC-V M-extension rules
    function automatic logic [63:0] ref_model(input int xlen, input logic [2:0] c,
                                              input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] mask, a, b;
        logic s1, s2;
        logic signed [129:0] sa, sb, p;
        logic [129:0] pu;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a = a_in & mask;
        b = b_in & mask;
        s1 = (c == 3'd1) || (c == 3'd2) || (c == 3'd4) || (c == 3'd6);
        s2 = (c == 3'd1) || (c == 3'd4) || (c == 3'd6);
        sa = $signed({66'd0, a});
        sb = $signed({66'd0, b});
        if (s1 && a[xlen-1]) sa = sa - (130'sd1 <<< xlen);
        if (s2 && b[xlen-1]) sb = sb - (130'sd1 <<< xlen);
        if (c[2] == 1'b0) begin
            p = sa * sb;
            pu = p;
            if (c != 3'd0) pu = pu >> xlen;
            return pu[63:0] & mask;
        end
        if (b == 64'd0) return c[1] ? a : mask;
        p = c[1] ? (sa % sb) : (sa / sb);
        pu = p;
        return pu[63:0] & mask;
    endfunction

    function automatic int exp_lat(input int xlen, input int bpc, input logic [2:0] c,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, minv;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        minv = 64'd1 << (xlen - 1);
        if (c[2] == 1'b0) return xlen / bpc + 1;
        if ((b & mask) == 64'd0) return 1;
        if ((c == 3'd4 || c == 3'd6) && (a & mask) == minv && (b & mask) == mask) return 1;
        return xlen + 2;
    endfunction

    // Issue one command to both 32-bit units and check result, latency, pulse width and busy
    task automatic run32(input string name, input logic [2:0] c, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_res,
                         input int lat_a_exp, input int lat_b_exp);
        int lat_a, lat_b, n_a, n_b;
        logic [31:0] got_a, got_b;
        logic busy_ok;
        cmd = type_scr1_ialu_md_cmd_e'(c);
        op1 = x; op2 = y; vd_a = 1'b1; vd_b = 1'b1;
        lat_a = -1; lat_b = -1; n_a = 0; n_b = 0; busy_ok = 1'b1;
        got_a = 'x; got_b = 'x;
        for (int cyc = 1; cyc <= 80 && (lat_a < 0 || lat_b < 0); cyc++) begin
            @(posedge clk); #1;
            if (rdy_a) begin
                n_a++;
                if (lat_a < 0) begin lat_a = cyc; got_a = res_a; vd_a = 1'b0; end
            end else if (lat_a < 0 && !busy_a) busy_ok = 1'b0;
            if (rdy_b) begin
                n_b++;
                if (lat_b < 0) begin lat_b = cyc; got_b = res_b; vd_b = 1'b0; end
            end else if (lat_b < 0 && !busy_b) busy_ok = 1'b0;
        end
        vd_a = 1'b0; vd_b = 1'b0;
        @(posedge clk); #1;
        if (rdy_a) n_a++;
        if (rdy_b) n_b++;
        check({name, " res_b1"}, 64'(got_a), 64'(exp_res));
        check({name, " res_b4"}, 64'(got_b), 64'(exp_res));
        check({name, " lat_b1"}, 64'(lat_a), 64'(lat_a_exp));
        check({name, " lat_b4"}, 64'(lat_b), 64'(lat_b_exp));
        check({name, " pulse"}, 64'({n_a[7:0], n_b[7:0]}), 64'h0101);
        check({name, " busy"}, 64'({busy_ok, busy_a, busy_b}), 64'b100);
    endtask

    task automatic run64(input string name, input logic [2:0] c, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] exp_res, input int lat_exp);
        int lat;
        logic [63:0] got;
        cmd = type_scr1_ialu_md_cmd_e'(c);
        op1_w = x; op2_w = y; vd_w = 1'b1;
        lat = -1; got = 'x;
        for (int cyc = 1; cyc <= 100 && lat < 0; cyc++) begin
            @(posedge clk); #1;
            if (rdy_w) begin lat = cyc; got = res_w; vd_w = 1'b0; end
        end
        vd_w = 1'b0;
        @(posedge clk); #1;
        check({name, " res64"}, got, exp_res);
        check({name, " lat64"}, 64'(lat), 64'(lat_exp));
        check({name, " idle64"}, 64'({rdy_w, busy_w}), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat_a;
        int          lat_b;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int n_rdy;
        logic [2:0] c;
        logic [31:0] x, y;
        logic [63:0] xw, yw, ew;

        vecs[0]  = '{"mul_7x6",      3'd0, 32'd7,          32'd6,          32'h0000_002A, 33, 9};
        vecs[1]  = '{"mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33, 9};
        vecs[2]  = '{"mulhu_ones",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33, 9};
        vecs[3]  = '{"mulhsu_m1x2",  3'd2, 32'hFFFF_FFFF,  32'h0000_0002,  32'hFFFF_FFFF, 33, 9};
        vecs[4]  = '{"mul_neg",      3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 33, 9};
        vecs[5]  = '{"mulhsu_min",   3'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 33, 9};
        vecs[6]  = '{"div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 34, 34};
        vecs[7]  = '{"rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 34, 34};
        vecs[8]  = '{"divu_100_7",   3'd5, 32'd100,        32'd7,          32'd14,        34, 34};
        vecs[9]  = '{"remu_100_7",   3'd7, 32'd100,        32'd7,          32'd2,         34, 34};
        vecs[10] = '{"div_7_m2",     3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 34, 34};
        vecs[11] = '{"rem_7_m2",     3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,         34, 34};
        vecs[12] = '{"divu_by0",     3'd5, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF, 1,  1};
        vecs[13] = '{"remu_by0",     3'd7, 32'h0000_1234,  32'd0,          32'h0000_1234, 1,  1};
        vecs[14] = '{"div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1,  1};
        vecs[15] = '{"rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1,  1};

        rst_n = 1'b0; kill = 1'b0; vd_a = 1'b0; vd_b = 1'b0; vd_w = 1'b0;
        cmd = SCR1_IALU_MD_CMD_MUL; op1 = 32'd0; op2 = 32'd0; op1_w = 64'd0; op2_w = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 64'({rdy_a, busy_a, res_a}), 64'd0);
        check("reset_b", 64'({rdy_b, busy_b, res_b}), 64'd0);
        check("reset_w", {63'd0, rdy_w | busy_w} | res_w, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            run32(vecs[i].name, vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].exp,
                  vecs[i].lat_a, vecs[i].lat_b);

        // Kill ten cycles into a divide: no result, idle next cycle, then a normal MUL
        cmd = SCR1_IALU_MD_CMD_DIVU; op1 = 32'd1000; op2 = 32'd3; vd_a = 1'b1; vd_b = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        kill = 1'b1; vd_a = 1'b0; vd_b = 1'b0;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_idle", 64'({rdy_a, busy_a, rdy_b, busy_b}), 64'd0);
        n_rdy = 0;
        repeat (40) begin @(posedge clk); #1; if (rdy_a || rdy_b) n_rdy++; end
        check("kill_no_result", 64'(n_rdy), 64'd0);
        run32("mul_3x5_after_kill", 3'd0, 32'd3, 32'd5, 32'd15, 33, 9);

        // Kill during DONE: output already shown, unit still returns to IDLE
        cmd = SCR1_IALU_MD_CMD_DIVU; op1 = 32'd77; op2 = 32'd0; vd_a = 1'b1; vd_b = 1'b0;
        @(posedge clk); #1;
        check("kill_done_res", 64'({rdy_a, res_a}), {31'd0, 1'b1, 32'hFFFF_FFFF});
        kill = 1'b1; vd_a = 1'b0;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_done_idle", 64'({rdy_a, busy_a, res_a}), 64'd0);

        // Reset mid-multiply
        cmd = SCR1_IALU_MD_CMD_MUL; op1 = 32'h1234; op2 = 32'h5678; vd_a = 1'b1; vd_b = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0; vd_a = 1'b0; vd_b = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_a", 64'({rdy_a, busy_a, res_a}), 64'd0);
        check("rst_mid_b", 64'({rdy_b, busy_b, res_b}), 64'd0);
        run32("mulhu_after_rst", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 33, 9);

        // 64-bit unit
        run64("mul64_pow", 3'd0, 64'd1 << 40, 64'd1 << 30, 64'd0, 9);
        run64("mulhu64_pow", 3'd3, 64'd1 << 40, 64'd1 << 30, 64'h40, 9);
        for (int i = 0; i < 6; i++) begin
            c = 3'($urandom_range(0, 7));
            xw = {$urandom, $urandom};
            yw = (i == 5) ? 64'd0 : {32'($urandom_range(0, 3)), $urandom};
            ew = ref_model(64, c, xw, yw);
            run64($sformatf("rnd64_%0d_c%0d", i, c), c, xw, yw, ew, exp_lat(64, 8, c, xw, yw));
        end

        // Randomized 32-bit commands, biased towards divider corner cases
        for (int i = 0; i < 40; i++) begin
            c = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 20));
                3: y = 32'hFFFF_FFFF;
                default: ;
            endcase
            xw = ref_model(32, c, {32'd0, x}, {32'd0, y});
            run32($sformatf("rnd32_%0d_c%0d", i, c), c, x, y, xw[31:0],
                  exp_lat(32, 1, c, {32'd0, x}, {32'd0, y}),
                  exp_lat(32, 4, c, {32'd0, x}, {32'd0, y}));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
